counter_scheduler: RTL and testbench

COUNTER_SCHEDULER -- requirements
Module: counter_scheduler

---
 rtl/counter_scheduler.sv | 154 +++++++++++++++
 tb/tb_counter_scheduler.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/counter_scheduler.sv
// Round-robin scheduler granting two requesters timed runs of a shared 32-bit counter.
// Optional macro COUNTER_SCHED_OVF_ABORT_EN: counter overflow (CNT_RCO) ends a run early and raises OVF.
module counter_scheduler #(
  parameter int LEN_W = 8
) (
  input  logic             CLK,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic             REQ1,
  input  logic [1:0]       CMD0_MODO,
  input  logic [1:0]       CMD1_MODO,
  input  logic [31:0]      CMD0_D,
  input  logic [31:0]      CMD1_D,
  input  logic [LEN_W-1:0] CMD0_LEN,
  input  logic [LEN_W-1:0] CMD1_LEN,
  output logic             GNT0,
  output logic             GNT1,
  output logic             DONE0,
  output logic             DONE1,
  output logic             CNT_ENABLE,
  output logic [1:0]       CNT_MODO,
  output logic [31:0]      CNT_D,
  input  logic             CNT_RCO,
  output logic             OVF,
  output logic             BUSY
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  localparam logic [1:0] MODO_LOAD = 2'b11;

  state_t           state, state_nxt;
  logic             owner;     // requester currently holding the counter
  logic             ptr;       // requester preferred when both ask
  logic [1:0]       modo_q;
  logic [31:0]      d_q;
  logic [LEN_W-1:0] left_q;    // RUN cycles remaining, including the current one

  logic             any_req;
  logic             win;
  logic [1:0]       sel_modo;
  logic [31:0]      sel_d;
  logic [LEN_W-1:0] sel_len;
  logic [LEN_W-1:0] run_len;
  logic             last_cycle;

  // Arbitration and command selection, only consumed in IDLE
  always_comb begin
    any_req  = REQ0 | REQ1;
    win      = (REQ0 && REQ1) ? ptr : REQ1;
    sel_modo = win ? CMD1_MODO : CMD0_MODO;
    sel_d    = win ? CMD1_D    : CMD0_D;
    sel_len  = win ? CMD1_LEN  : CMD0_LEN;
    if (sel_modo == MODO_LOAD || sel_len == '0)
      run_len = LEN_W'(1);
    else
      run_len = sel_len;
  end

`ifdef COUNTER_SCHED_OVF_ABORT_EN
  logic ovf_q;
  assign last_cycle = (left_q == LEN_W'(1)) || CNT_RCO;
`else
  logic unused_rco;
  assign unused_rco = CNT_RCO;
  assign last_cycle = (left_q == LEN_W'(1));
`endif

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // NOTE: default assignment first so no path through the case infers a latch.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (any_req)    state_nxt = S_RUN;
      S_RUN:   if (last_cycle) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // NOTE: every control register is reset; the latched command is reset too so
  // CNT_* never leaks a stale value after an aborted run.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      owner  <= 1'b0;
      ptr    <= 1'b0;
      modo_q <= '0;
      d_q    <= '0;
      left_q <= '0;
`ifdef COUNTER_SCHED_OVF_ABORT_EN
      ovf_q  <= 1'b0;
`endif
    end else begin
      case (state)
        S_IDLE: if (any_req) begin
          owner  <= win;
          modo_q <= sel_modo;
          d_q    <= sel_d;
          left_q <= run_len;
`ifdef COUNTER_SCHED_OVF_ABORT_EN
          ovf_q  <= 1'b0;
`endif
        end
        S_RUN: begin
          left_q <= left_q - LEN_W'(1);
`ifdef COUNTER_SCHED_OVF_ABORT_EN
          if (last_cycle) ovf_q <= CNT_RCO;
`endif
        end
        S_DONE: ptr <= ~owner;
        default: ;
      endcase
    end
  end

  // Outputs decode purely from registered state, so reset clears them at once
  always_comb begin
    GNT0       = 1'b0;
    GNT1       = 1'b0;
    DONE0      = 1'b0;
    DONE1      = 1'b0;
    CNT_ENABLE = 1'b0;
    CNT_MODO   = 2'b00;
    CNT_D      = '0;
    OVF        = 1'b0;
    BUSY       = 1'b0;
    case (state)
      S_RUN: begin
        GNT0       = ~owner;
        GNT1       = owner;
        CNT_ENABLE = 1'b1;
        CNT_MODO   = modo_q;
        CNT_D      = d_q;
        BUSY       = 1'b1;
      end
      S_DONE: begin
        DONE0 = ~owner;
        DONE1 = owner;
        BUSY  = 1'b1;
`ifdef COUNTER_SCHED_OVF_ABORT_EN
        OVF   = ovf_q;
`endif
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_counter_scheduler.sv
// Self-checking bench for counter_scheduler: directed scenarios plus randomized runs
// checked against a transaction-level model (honours COUNTER_SCHED_OVF_ABORT_EN).
module tb_counter_scheduler;

  localparam int LEN_W = 8;

  logic             CLK = 1'b0;
  logic             RESET;
  logic             REQ0, REQ1;
  logic [1:0]       CMD0_MODO, CMD1_MODO;
  logic [31:0]      CMD0_D, CMD1_D;
  logic [LEN_W-1:0] CMD0_LEN, CMD1_LEN;
  logic             GNT0, GNT1, DONE0, DONE1;
  logic             CNT_ENABLE;
  logic [1:0]       CNT_MODO;
  logic [31:0]      CNT_D;
  logic             CNT_RCO;
  logic             OVF, BUSY;

  int n_vec = 0;
  int n_err = 0;
  bit next_pref = 1'b0;  // model: requester favoured on a tie

  counter_scheduler #(.LEN_W(LEN_W)) dut (
    .CLK(CLK), .RESET(RESET),
    .REQ0(REQ0), .REQ1(REQ1),
    .CMD0_MODO(CMD0_MODO), .CMD1_MODO(CMD1_MODO),
    .CMD0_D(CMD0_D), .CMD1_D(CMD1_D),
    .CMD0_LEN(CMD0_LEN), .CMD1_LEN(CMD1_LEN),
    .GNT0(GNT0), .GNT1(GNT1), .DONE0(DONE0), .DONE1(DONE1),
    .CNT_ENABLE(CNT_ENABLE), .CNT_MODO(CNT_MODO), .CNT_D(CNT_D),
    .CNT_RCO(CNT_RCO), .OVF(OVF), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

  function automatic logic [40:0] observe();
    return {GNT0, GNT1, DONE0, DONE1, CNT_ENABLE, CNT_MODO, CNT_D, OVF, BUSY};
  endfunction

  // One full transaction. Called inside an IDLE cycle; returns inside the IDLE
  // cycle that follows DONE. mode: 0 hold inputs, 1 drop REQs, 2 random junk.
  task automatic do_txn(input bit r0, input bit r1,
                        input logic [1:0] m0, input logic [1:0] m1,
                        input logic [31:0] d0, input logic [31:0] d1,
                        input logic [LEN_W-1:0] l0, input logic [LEN_W-1:0] l1,
                        input int rco_at, input int mode, input string tag);
    bit               w;
    bit               exp_ovf;
    int               eff, runc;
    logic [1:0]       wm;
    logic [31:0]      wd;
    logic [LEN_W-1:0] wl;
    logic [40:0]      exp_v, obs;
    REQ0 = r0; REQ1 = r1;
    CMD0_MODO = m0; CMD1_MODO = m1;
    CMD0_D = d0; CMD1_D = d1;
    CMD0_LEN = l0; CMD1_LEN = l1;
    CNT_RCO = 1'b0;
    w  = (r0 && r1) ? next_pref : r1;
    wm = w ? m1 : m0;
    wd = w ? d1 : d0;
    wl = w ? l1 : l0;
    eff = (wm == 2'b11) ? 1 : ((wl == 0) ? 1 : int'(wl));
    runc = eff;
    exp_ovf = 1'b0;
`ifdef COUNTER_SCHED_OVF_ABORT_EN
    if (rco_at >= 0 && rco_at < eff) begin
      runc = rco_at + 1;
      exp_ovf = 1'b1;
    end
`endif
    @(posedge CLK); #1;
    for (int i = 0; i < runc + 1; i++) begin
      if (mode == 1) begin
        REQ0 = 1'b0; REQ1 = 1'b0;
      end else if (mode == 2) begin
        REQ0 = 1'($urandom); REQ1 = 1'($urandom);
        CMD0_MODO = 2'($urandom); CMD1_MODO = 2'($urandom);
        CMD0_D = $urandom; CMD1_D = $urandom;
        CMD0_LEN = LEN_W'($urandom); CMD1_LEN = LEN_W'($urandom);
      end
      CNT_RCO = (i == rco_at);
      @(negedge CLK);
      if (i < runc)
        exp_v = {~w, w, 1'b0, 1'b0, 1'b1, wm, wd, 1'b0, 1'b1};
      else
        exp_v = {1'b0, 1'b0, ~w, w, 1'b0, 2'b00, 32'h0, exp_ovf, 1'b1};
      obs = observe();
      n_vec++;
      if (obs !== exp_v) begin
        n_err++;
        $display("FAIL %s %s cycle %0d: got %h expected %h", tag,
                 (i < runc) ? "run" : "done", i, obs, exp_v);
      end
      @(posedge CLK); #1;
    end
    REQ0 = 1'b0; REQ1 = 1'b0; CNT_RCO = 1'b0;
    @(negedge CLK);
    obs = observe();
    n_vec++;
    if (obs !== 41'h0) begin
      n_err++;
      $display("FAIL %s idle after done: got %h expected %h", tag, obs, 41'h0);
    end
    next_pref = ~w;
  endtask

  task automatic idle_cycles(input int n, input string tag);
    logic [40:0] obs;
    for (int i = 0; i < n; i++) begin
      @(posedge CLK); #1;
      @(negedge CLK);
      obs = observe();
      n_vec++;
      if (obs !== 41'h0) begin
        n_err++;
        $display("FAIL %s idle %0d: got %h expected %h", tag, i, obs, 41'h0);
      end
    end
  endtask

  task automatic test_reset();
    logic [40:0] obs;
    RESET = 1'b1; REQ0 = 1'b1; REQ1 = 1'b1; CNT_RCO = 1'b0;
    CMD0_MODO = 2'b00; CMD1_MODO = 2'b00;
    CMD0_D = 32'h1234_5678; CMD1_D = 32'h8765_4321;
    CMD0_LEN = 8'd3; CMD1_LEN = 8'd3;
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      obs = observe();
      n_vec++;
      if (obs !== 41'h0) begin
        n_err++;
        $display("FAIL reset_hold %0d: got %h expected %h", i, obs, 41'h0);
      end
    end
    REQ0 = 1'b0; REQ1 = 1'b0; RESET = 1'b0;
    next_pref = 1'b0;
    idle_cycles(1, "reset_release");
  endtask

  task automatic test_single_run();
    do_txn(1, 0, 2'b00, 2'b00, 32'h0, 32'h0, 8'd5, 8'd0, -1, 0, "single_len5");
  endtask

  task automatic test_alternation();
    for (int k = 0; k < 4; k++)
      do_txn(1, 1, 2'b00, 2'b01, 32'hA, 32'hB, 8'd2, 8'd2, -1, 0, "alternate");
  endtask

  task automatic test_load_mode();
    do_txn(0, 1, 2'b00, 2'b11, 32'h0, 32'hDEAD_BEEF, 8'd0, 8'd9, -1, 0, "load_mode");
  endtask

  task automatic test_len_zero_and_drop();
    do_txn(1, 0, 2'b10, 2'b00, 32'h5, 32'h0, 8'd0, 8'd0, -1, 0, "len_zero");
    do_txn(1, 0, 2'b01, 2'b00, 32'h7, 32'h0, 8'd4, 8'd0, -1, 1, "req_dropped");
  endtask

  task automatic test_overflow();
    do_txn(1, 0, 2'b00, 2'b00, 32'h0, 32'h0, 8'd10, 8'd0, 3, 0, "ovf_len10");
    do_txn(0, 1, 2'b11, 2'b11, 32'h0, 32'h0, 8'd0, 8'd5, 0, 0, "ovf_load");
  endtask

  task automatic test_reset_mid_run();
    logic [40:0] obs, exp_v;
    do_txn(1, 0, 2'b00, 2'b00, 32'h1, 32'h0, 8'd1, 8'd0, -1, 0, "pre_abort");
    REQ0 = 1'b1; REQ1 = 1'b0;
    CMD0_MODO = 2'b10; CMD0_D = 32'hCAFE_F00D; CMD0_LEN = 8'd6;
    @(posedge CLK); #1; REQ0 = 1'b0;
    @(posedge CLK); #1;
    @(posedge CLK); #2;
    exp_v = {1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 2'b10, 32'hCAFE_F00D, 1'b0, 1'b1};
    obs = observe();
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL abort_pre cycle 3: got %h expected %h", obs, exp_v);
    end
    RESET = 1'b1;
    #1;
    obs = observe();
    n_vec++;
    if (obs !== 41'h0) begin
      n_err++;
      $display("FAIL abort_async: got %h expected %h", obs, 41'h0);
    end
    for (int i = 0; i < 2; i++) begin
      @(negedge CLK);
      obs = observe();
      n_vec++;
      if (obs !== 41'h0) begin
        n_err++;
        $display("FAIL abort_hold %0d: got %h expected %h", i, obs, 41'h0);
      end
    end
    RESET = 1'b0;
    next_pref = 1'b0;
    do_txn(1, 1, 2'b00, 2'b00, 32'h2, 32'h3, 8'd2, 8'd2, -1, 0, "post_reset_tie");
    do_txn(0, 1, 2'b00, 2'b01, 32'h0, 32'h77, 8'd0, 8'd3, -1, 0, "post_reset_req1");
  endtask

  task automatic test_random();
    bit r0, r1;
    int rco_at;
    for (int k = 0; k < 40; k++) begin
      r0 = 1'($urandom);
      r1 = 1'($urandom);
      if (!r0 && !r1) r1 = 1'b1;
      rco_at = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 12)) : -1;
      do_txn(r0, r1, 2'($urandom), 2'($urandom), $urandom, $urandom,
             LEN_W'($urandom_range(0, 12)), LEN_W'($urandom_range(0, 12)),
             rco_at, 2, "random");
      if ($urandom_range(0, 3) == 0) idle_cycles(int'($urandom_range(1, 3)), "random_gap");
    end
  endtask

  initial begin
    test_reset();
    test_alternation();
    test_single_run();
    test_load_mode();
    test_len_zero_and_drop();
    test_overflow();
    test_reset_mid_run();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
